// File: rtl/axis_byte_packer.sv
// Packs a byte-wide AXI-stream into FIFO_WIDTH-byte words for the FIFO write side,
// carrying frame start (tuser) and end (tlast) markers plus a valid-byte count.
module axis_byte_packer #(
  parameter int          FIFO_WIDTH = 2,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                               aclk,
  input  logic                               rst,
  input  logic [7:0]                         s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic                               s_tuser,
  input  logic                               s_tlast,
  output logic [8*FIFO_WIDTH-1:0]            m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               m_tuser,
  output logic                               m_tlast,
  output logic [$clog2(FIFO_WIDTH+1)-1:0]    m_bytes,
  output logic [7:0]                         sof_err_cnt
);

  localparam int IDX_W = $clog2(FIFO_WIDTH);
  localparam int BW    = $clog2(FIFO_WIDTH + 1);
  localparam int W     = 8 * FIFO_WIDTH;

  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(FIFO_WIDTH - 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_OUT  = 1'b1;

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic             sof_r;
  logic [W-1:0]     acc_r;
  logic [7:0]       err_cnt_r;
  logic [W-1:0]     m_data_r;
  logic             m_tuser_r;
  logic             m_tlast_r;
  logic [BW-1:0]    m_bytes_r;

  logic             accept_s;
  logic             restart_s;
  logic             close_s;
  logic [IDX_W-1:0] lane_s;
  logic [W-1:0]     word_s;
  logic             word_tuser_s;

  assign m_valid     = (state_r == ST_OUT);
  assign s_ready     = !rst & (!m_valid | m_ready);
  assign m_data      = m_data_r;
  assign m_tuser     = m_tuser_r;
  assign m_tlast     = m_tlast_r;
  assign m_bytes     = m_bytes_r;
  assign sof_err_cnt = err_cnt_r;

  // Handshake decode: a tuser byte mid-word restarts the word at lane 0.
  always_comb begin
    accept_s  = s_valid & s_ready;
    restart_s = accept_s & s_tuser & (idx_r != {IDX_W{1'b0}});
    if (restart_s) begin
      lane_s = {IDX_W{1'b0}};
    end else begin
      lane_s = idx_r;
    end
    close_s = accept_s & ((lane_s == LAST_LANE) | s_tlast);
    if (lane_s == {IDX_W{1'b0}}) begin
      word_tuser_s = s_tuser;
    end else begin
      word_tuser_s = sof_r;
    end
  end

  // Closing word: stored lanes below the incoming byte, padding above it.
  always_comb begin
    word_s = {W{1'b0}};
    for (int i = 0; i < FIFO_WIDTH; i++) begin
      if (i < int'(lane_s)) begin
        word_s[i*8 +: 8] = acc_r[i*8 +: 8];
      end else if (i == int'(lane_s)) begin
        word_s[i*8 +: 8] = s_data;
      end else begin
        word_s[i*8 +: 8] = PAD_BYTE;
      end
    end
  end

  // Output state: FILL while no word is held, OUT while m_valid is high.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (close_s) begin
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_OUT: begin
        if (close_s) begin
          state_nxt_s = ST_OUT;
        end else if (m_ready) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_FILL;
    endcase
  end

  // Accumulator, output register and error counter.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_r   <= ST_FILL;
      idx_r     <= {IDX_W{1'b0}};
      sof_r     <= 1'b0;
      acc_r     <= {W{1'b0}};
      err_cnt_r <= 8'h00;
      m_data_r  <= {W{1'b0}};
      m_tuser_r <= 1'b0;
      m_tlast_r <= 1'b0;
      m_bytes_r <= {BW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        if (close_s) begin
          idx_r <= {IDX_W{1'b0}};
          sof_r <= 1'b0;
        end else begin
          acc_r[{lane_s, 3'b000} +: 8] <= s_data;
          idx_r                        <= lane_s + IDX_W'(1);
          sof_r                        <= word_tuser_s;
        end
      end
      if (restart_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'h01;
      end
      // Word fields only change on a close, so they hold while stalled.
      if (close_s) begin
        m_data_r  <= word_s;
        m_tuser_r <= word_tuser_s;
        m_tlast_r <= s_tlast;
        m_bytes_r <= BW'(lane_s) + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed self-checking bench for axis_byte_packer with FIFO_WIDTH=2.
module tb_axis_byte_packer;

  typedef struct packed {
    logic [15:0] data;
    logic        tuser;
    logic        tlast;
    logic [1:0]  bytes;
  } word_t;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_tuser;
  logic        m_tlast;
  logic [1:0]  m_bytes;
  logic [7:0]  sof_err_cnt;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    stall_cycles = 0;
  word_t mon_q[$];
  int    cyc_q[$];

  axis_byte_packer #(.FIFO_WIDTH(2), .PAD_BYTE(8'h00)) dut (
    .aclk(aclk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .m_bytes(m_bytes),
    .sof_err_cnt(sof_err_cnt)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Record every word that will be handshaken at the coming rising edge.
  always @(negedge aclk) begin
    #1;
    if (!rst && m_valid && m_ready) begin
      mon_q.push_back({m_data, m_tuser, m_tlast, m_bytes});
      cyc_q.push_back(cyc);
    end
  end

  task automatic put(input logic [7:0] d, input logic tu, input logic tl);
    int guard;
    guard = 0;
    s_data = d; s_tuser = tu; s_tlast = tl; s_valid = 1'b1;
    while (!s_ready && guard < 100) begin
      @(negedge aclk);
      guard++;
    end
    stall_cycles += guard;
    if (guard >= 100) begin
      tests++; fails++;
      $display("FAIL put_timeout byte=%h s_ready stayed %b, required 1", d, s_ready);
    end
    @(negedge aclk);
    s_valid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic check_word(input string name, input int k, input word_t exp);
    word_t got;
    got = (k < mon_q.size()) ? mon_q[k] : '0;
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s word%0d got data=%h tuser=%b tlast=%b bytes=%0d, required data=%h tuser=%b tlast=%b bytes=%0d",
               name, k, got.data, got.tuser, got.tlast, got.bytes, exp.data, exp.tuser, exp.tlast, exp.bytes);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge aclk);
    tests++;
    if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got %b, required 0", s_ready); end
    tests++;
    if ({m_valid, m_data, m_tuser, m_tlast, m_bytes, sof_err_cnt} !== 29'd0) begin
      fails++;
      $display("FAIL reset_outputs got valid=%b data=%h tuser=%b tlast=%b bytes=%0d cnt=%0d, required all 0",
               m_valid, m_data, m_tuser, m_tlast, m_bytes, sof_err_cnt);
    end
    rst = 1'b0;
    @(negedge aclk);
    tests++;
    if (s_ready !== 1'b1) begin fails++; $display("FAIL post_reset_s_ready got %b, required 1", s_ready); end
    tests++;
    if (m_valid !== 1'b0) begin fails++; $display("FAIL post_reset_m_valid got %b, required 0", m_valid); end
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    mon_q.delete(); cyc_q.delete();
    put(8'hA1, 1'b1, 1'b0);
    tests++;
    if (m_valid !== 1'b0) begin fails++; $display("FAIL basic_no_early_valid got %b, required 0", m_valid); end
    put(8'hA2, 1'b0, 1'b0);
    tests++;
    if (m_valid !== 1'b1 || m_data !== 16'hA2A1) begin
      fails++;
      $display("FAIL basic_latency got valid=%b data=%h, required valid=1 data=a2a1", m_valid, m_data);
    end
    put(8'hA3, 1'b0, 1'b1);
    repeat (3) @(negedge aclk);
    tests++;
    if (mon_q.size() != 2) begin fails++; $display("FAIL basic_count got %0d, required 2", mon_q.size()); end
    check_word("basic", 0, '{data: 16'hA2A1, tuser: 1'b1, tlast: 1'b0, bytes: 2'd2});
    check_word("basic", 1, '{data: 16'h00A3, tuser: 1'b0, tlast: 1'b1, bytes: 2'd1});
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    mon_q.delete(); cyc_q.delete();
    stall_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      put(8'h10 + 8'(i), (i == 0), (i == 7));
    end
    repeat (3) @(negedge aclk);
    tests++;
    if (stall_cycles != 0) begin fails++; $display("FAIL b2b_s_ready_drop got %0d stalls, required 0", stall_cycles); end
    tests++;
    if (mon_q.size() != 4) begin fails++; $display("FAIL b2b_count got %0d, required 4", mon_q.size()); end
    check_word("b2b", 0, '{data: 16'h1110, tuser: 1'b1, tlast: 1'b0, bytes: 2'd2});
    check_word("b2b", 1, '{data: 16'h1312, tuser: 1'b0, tlast: 1'b0, bytes: 2'd2});
    check_word("b2b", 2, '{data: 16'h1514, tuser: 1'b0, tlast: 1'b0, bytes: 2'd2});
    check_word("b2b", 3, '{data: 16'h1716, tuser: 1'b0, tlast: 1'b1, bytes: 2'd2});
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (cyc_q.size() != 4 || cyc_q[k+1] - cyc_q[k] != 2) begin
        fails++;
        $display("FAIL b2b_spacing word%0d got gap %0d, required 2", k,
                 (cyc_q.size() == 4) ? cyc_q[k+1] - cyc_q[k] : -1);
      end
    end
  endtask

  task automatic test_stall();
    m_ready = 1'b0;
    mon_q.delete(); cyc_q.delete();
    put(8'hE1, 1'b1, 1'b0);
    put(8'hE2, 1'b0, 1'b0);
    s_data = 8'hE3; s_tuser = 1'b0; s_tlast = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 16'hE2E1) begin
        fails++;
        $display("FAIL stall_hold cycle%0d got s_ready=%b valid=%b data=%h, required s_ready=0 valid=1 data=e2e1",
                 k, s_ready, m_valid, m_data);
      end
      @(negedge aclk);
    end
    m_ready = 1'b1;
    @(negedge aclk);
    s_valid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(negedge aclk);
    tests++;
    if (mon_q.size() != 2) begin fails++; $display("FAIL stall_count got %0d, required 2", mon_q.size()); end
    check_word("stall", 0, '{data: 16'hE2E1, tuser: 1'b1, tlast: 1'b0, bytes: 2'd2});
    check_word("stall", 1, '{data: 16'h00E3, tuser: 1'b0, tlast: 1'b1, bytes: 2'd1});
    tests++;
    if (cyc_q.size() != 2 || cyc_q[1] - cyc_q[0] != 1) begin
      fails++;
      $display("FAIL stall_back_to_back got gap %0d, required 1", (cyc_q.size() == 2) ? cyc_q[1] - cyc_q[0] : -1);
    end
  endtask

  task automatic test_sof_err();
    m_ready = 1'b1;
    mon_q.delete(); cyc_q.delete();
    put(8'hB1, 1'b1, 1'b0);
    put(8'hC1, 1'b1, 1'b0);
    tests++;
    if (sof_err_cnt !== 8'd1) begin fails++; $display("FAIL sof_err_cnt got %0d, required 1", sof_err_cnt); end
    put(8'hC2, 1'b0, 1'b1);
    repeat (3) @(negedge aclk);
    tests++;
    if (mon_q.size() != 1) begin fails++; $display("FAIL sof_count got %0d, required 1", mon_q.size()); end
    check_word("sof", 0, '{data: 16'hC2C1, tuser: 1'b1, tlast: 1'b1, bytes: 2'd2});
  endtask

  task automatic test_saturation();
    m_ready = 1'b1;
    // Counter is 1 here; each tuser byte after the first adds one error.
    for (int i = 0; i < 254; i++) put(8'(i), 1'b1, 1'b0);
    tests++;
    if (sof_err_cnt !== 8'hFE) begin fails++; $display("FAIL sat_pre got %h, required fe", sof_err_cnt); end
    for (int i = 0; i < 47; i++) put(8'(i), 1'b1, 1'b0);
    tests++;
    if (sof_err_cnt !== 8'hFF) begin fails++; $display("FAIL sat_hold got %h, required ff", sof_err_cnt); end
    put(8'h77, 1'b0, 1'b1);
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    put(8'hF1, 1'b1, 1'b0);
    put(8'hF2, 1'b0, 1'b0);
    tests++;
    if (m_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pending got %b, required 1", m_valid); end
    rst = 1'b1;
    @(negedge aclk);
    tests++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || sof_err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rstmid_drop got valid=%b s_ready=%b cnt=%0d, required 0 0 0", m_valid, s_ready, sof_err_cnt);
    end
    rst = 1'b0;
    m_ready = 1'b1;
    mon_q.delete(); cyc_q.delete();
    put(8'hB1, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge aclk);
    rst = 1'b0;
    @(negedge aclk);
    put(8'hD1, 1'b1, 1'b1);
    repeat (3) @(negedge aclk);
    tests++;
    if (mon_q.size() != 1) begin fails++; $display("FAIL rstmid_count got %0d, required 1", mon_q.size()); end
    check_word("rstmid", 0, '{data: 16'h00D1, tuser: 1'b1, tlast: 1'b1, bytes: 2'd1});
    tests++;
    if (sof_err_cnt !== 8'd0) begin fails++; $display("FAIL rstmid_cnt got %0d, required 0", sof_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_sof_err();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
